ex_mem_reg: RTL and testbench

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/ex_mem_reg_if.sv | 57 +++++
 rtl/ex_mem_reg.sv | 143 ++++++++++++++
 tb/tb_ex_mem_reg.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_reg_if.sv
// EX/MEM pipeline register bundle: EX-side fields in, MEM-side fields out.
// master drives the EX side and stall/flush; slave is the register itself.
interface ex_mem_reg_if #(
    parameter int WIDTH = 16,
    parameter int RD_W  = 3
);
    logic             stall;
    logic             flush;
    logic             ex_valid;
    logic [WIDTH-1:0] ex_alu_out;
    logic             ex_cout;
    logic             ex_v;
    logic             ex_lt;
    logic             ex_eq;
    logic             ex_gt;
    logic [3:0]       ex_opcod;
    logic [RD_W-1:0]  ex_rd;
    logic             ex_regwrite;
    logic             ex_memread;
    logic             ex_memwrite;
    logic [WIDTH-1:0] ex_store_data;
    logic [WIDTH-1:0] ex_br_target;
    logic [2:0]       ex_br_cond;

    logic             mem_valid;
    logic [WIDTH-1:0] mem_alu_out;
    logic [WIDTH-1:0] mem_store_data;
    logic [RD_W-1:0]  mem_rd;
    logic             mem_regwrite;
    logic             mem_memread;
    logic             mem_memwrite;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic [4:0]       flags;
    logic [7:0]       ovf_count;
    logic             ovf_exc;

    modport master (
        output stall, flush, ex_valid, ex_alu_out, ex_cout, ex_v,
        output ex_lt, ex_eq, ex_gt, ex_opcod, ex_rd, ex_regwrite,
        output ex_memread, ex_memwrite, ex_store_data, ex_br_target,
        output ex_br_cond,
        input  mem_valid, mem_alu_out, mem_store_data, mem_rd,
        input  mem_regwrite, mem_memread, mem_memwrite, br_taken,
        input  br_target, flags, ovf_count, ovf_exc
    );

    modport slave (
        input  stall, flush, ex_valid, ex_alu_out, ex_cout, ex_v,
        input  ex_lt, ex_eq, ex_gt, ex_opcod, ex_rd, ex_regwrite,
        input  ex_memread, ex_memwrite, ex_store_data, ex_br_target,
        input  ex_br_cond,
        output mem_valid, mem_alu_out, mem_store_data, mem_rd,
        output mem_regwrite, mem_memread, mem_memwrite, br_taken,
        output br_target, flags, ovf_count, ovf_exc
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with branch resolve, sticky ALU flags and
// saturating overflow counter. Define EXMEM_OVF_TRAP_EN to trap overflows.
module ex_mem_reg #(
    parameter int WIDTH = 16,
    parameter int RD_W  = 3
) (
    input logic           clk,
    input logic           rst,
    ex_mem_reg_if.slave   bus
);
    localparam logic [3:0] OP_ADDU = 4'b0000;
    localparam logic [3:0] OP_ADDS = 4'b0001;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic [WIDTH-1:0] store_data_q, store_data_d;
    logic [RD_W-1:0]  rd_q, rd_d;
    logic             regwrite_q, regwrite_d;
    logic             memread_q, memread_d;
    logic             memwrite_q, memwrite_d;
    logic             br_taken_q, br_taken_d;
    logic [WIDTH-1:0] br_target_q, br_target_d;
    logic [4:0]       flags_q, flags_d;
    logic [7:0]       ovf_count_q, ovf_count_d;
    logic             ovf_exc_q, ovf_exc_d;

    logic cond_met;
    logic arith_op;
    logic ovf_hit;
    logic trap;

    assign arith_op = bus.ex_valid &&
                      (bus.ex_opcod == OP_ADDU || bus.ex_opcod == OP_ADDS);
    assign ovf_hit  = bus.ex_valid && (bus.ex_opcod == OP_ADDS) && bus.ex_v;

`ifdef EXMEM_OVF_TRAP_EN
    assign trap = ovf_hit;
`else
    assign trap = 1'b0;
`endif

    // Branch condition select on the compare flags
    always_comb begin
        cond_met = 1'b0;
        unique case (bus.ex_br_cond)
            3'b000: cond_met = 1'b0;
            3'b001: cond_met = bus.ex_eq;
            3'b010: cond_met = !bus.ex_eq;
            3'b011: cond_met = bus.ex_lt;
            3'b100: cond_met = bus.ex_gt;
            3'b101: cond_met = bus.ex_lt || bus.ex_eq;
            3'b110: cond_met = bus.ex_gt || bus.ex_eq;
            3'b111: cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    end

    // Next-state: flush squashes controls, stall holds, otherwise load
    always_comb begin
        valid_d      = valid_q;
        alu_out_d    = alu_out_q;
        store_data_d = store_data_q;
        rd_d         = rd_q;
        regwrite_d   = regwrite_q;
        memread_d    = memread_q;
        memwrite_d   = memwrite_q;
        br_taken_d   = br_taken_q;
        br_target_d  = br_target_q;
        flags_d      = flags_q;
        ovf_count_d  = ovf_count_q;
        ovf_exc_d    = 1'b0;

        if (bus.flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            br_taken_d = 1'b0;
        end else if (!bus.stall) begin
            valid_d      = bus.ex_valid;
            alu_out_d    = bus.ex_alu_out;
            store_data_d = bus.ex_store_data;
            rd_d         = bus.ex_rd;
            regwrite_d   = bus.ex_valid && bus.ex_regwrite && !trap;
            memread_d    = bus.ex_valid && bus.ex_memread;
            memwrite_d   = bus.ex_valid && bus.ex_memwrite && !trap;
            br_taken_d   = bus.ex_valid && cond_met && !trap;
            br_target_d  = bus.ex_br_target;
            ovf_exc_d    = trap;
            if (arith_op) begin
                flags_d = {bus.ex_v, bus.ex_cout,
                           bus.ex_lt, bus.ex_eq, bus.ex_gt};
            end
            if (ovf_hit && ovf_count_q != 8'hFF) begin
                ovf_count_d = ovf_count_q + 8'd1;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            alu_out_q    <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            regwrite_q   <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            br_taken_q   <= 1'b0;
            br_target_q  <= '0;
            flags_q      <= '0;
            ovf_count_q  <= '0;
            ovf_exc_q    <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            alu_out_q    <= alu_out_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
            regwrite_q   <= regwrite_d;
            memread_q    <= memread_d;
            memwrite_q   <= memwrite_d;
            br_taken_q   <= br_taken_d;
            br_target_q  <= br_target_d;
            flags_q      <= flags_d;
            ovf_count_q  <= ovf_count_d;
            ovf_exc_q    <= ovf_exc_d;
        end
    end

    assign bus.mem_valid      = valid_q;
    assign bus.mem_alu_out    = alu_out_q;
    assign bus.mem_store_data = store_data_q;
    assign bus.mem_rd         = rd_q;
    assign bus.mem_regwrite   = regwrite_q;
    assign bus.mem_memread    = memread_q;
    assign bus.mem_memwrite   = memwrite_q;
    assign bus.br_taken       = br_taken_q;
    assign bus.br_target      = br_target_q;
    assign bus.flags          = flags_q;
    assign bus.ovf_count      = ovf_count_q;
    assign bus.ovf_exc        = ovf_exc_q;
endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: reset, load, flags, branch, stall/flush,
// overflow counting and saturation; trap expectations follow the macro.
module tb_ex_mem_reg;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

`ifdef EXMEM_OVF_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    ex_mem_reg_if #(.WIDTH(16), .RD_W(3)) bus ();

    ex_mem_reg #(.WIDTH(16), .RD_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        bus.ex_valid      = 1'($urandom);
        bus.ex_alu_out    = 16'($urandom);
        bus.ex_cout       = 1'($urandom);
        bus.ex_v          = 1'($urandom);
        bus.ex_lt         = 1'($urandom);
        bus.ex_eq         = 1'($urandom);
        bus.ex_gt         = 1'($urandom);
        bus.ex_opcod      = 4'($urandom);
        bus.ex_rd         = 3'($urandom);
        bus.ex_regwrite   = 1'($urandom);
        bus.ex_memread    = 1'($urandom);
        bus.ex_memwrite   = 1'($urandom);
        bus.ex_store_data = 16'($urandom);
        bus.ex_br_target  = 16'($urandom);
        bus.ex_br_cond    = 3'($urandom);
    endtask

    task automatic clr_inputs();
        bus.ex_valid      = 1'b1;
        bus.ex_alu_out    = '0;
        bus.ex_cout       = 1'b0;
        bus.ex_v          = 1'b0;
        bus.ex_lt         = 1'b0;
        bus.ex_eq         = 1'b0;
        bus.ex_gt         = 1'b0;
        bus.ex_opcod      = 4'b0000;
        bus.ex_rd         = '0;
        bus.ex_regwrite   = 1'b0;
        bus.ex_memread    = 1'b0;
        bus.ex_memwrite   = 1'b0;
        bus.ex_store_data = '0;
        bus.ex_br_target  = '0;
        bus.ex_br_cond    = 3'b000;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, 32'(bus.mem_valid), 32'd0);
        chk({tag, ".alu"}, 32'(bus.mem_alu_out), 32'd0);
        chk({tag, ".sdata"}, 32'(bus.mem_store_data), 32'd0);
        chk({tag, ".rd"}, 32'(bus.mem_rd), 32'd0);
        chk({tag, ".ctl"}, 32'({bus.mem_regwrite, bus.mem_memread,
                                bus.mem_memwrite}), 32'd0);
        chk({tag, ".br"}, 32'(bus.br_taken), 32'd0);
        chk({tag, ".brt"}, 32'(bus.br_target), 32'd0);
        chk({tag, ".flags"}, 32'(bus.flags), 32'd0);
        chk({tag, ".ovfc"}, 32'(bus.ovf_count), 32'd0);
        chk({tag, ".exc"}, 32'(bus.ovf_exc), 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // reset for two cycles under random inputs
        rst        = 1'b1;
        bus.stall  = 1'($urandom);
        bus.flush  = 1'($urandom);
        rand_inputs();
        step();
        rand_inputs();
        step();
        chk_all_zero("reset");

        // basic unsigned add load
        rst       = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        clr_inputs();
        bus.ex_alu_out    = 16'd500;
        bus.ex_rd         = 3'd3;
        bus.ex_regwrite   = 1'b1;
        bus.ex_store_data = 16'h1234;
        bus.ex_br_target  = 16'h0040;
        step();
        chk("load.alu", 32'(bus.mem_alu_out), 32'd500);
        chk("load.rd", 32'(bus.mem_rd), 32'd3);
        chk("load.rw", 32'(bus.mem_regwrite), 32'd1);
        chk("load.valid", 32'(bus.mem_valid), 32'd1);
        chk("load.flags", 32'(bus.flags), 32'd0);
        chk("load.sdata", 32'(bus.mem_store_data), 32'h1234);
        chk("load.brt", 32'(bus.br_target), 32'h0040);
        chk("load.br", 32'(bus.br_taken), 32'd0);

        // add updates flags: C=1 lt=1
        bus.ex_cout = 1'b1;
        bus.ex_lt   = 1'b1;
        step();
        chk("addflags", 32'(bus.flags), 32'b01100);

        // logic op leaves flags, ex_v ignored
        bus.ex_opcod = 4'b0010;
        bus.ex_cout  = 1'b0;
        bus.ex_lt    = 1'b0;
        bus.ex_v     = 1'b1;
        bus.ex_gt    = 1'b1;
        step();
        chk("logic.flags", 32'(bus.flags), 32'b01100);
        chk("logic.ovfc", 32'(bus.ovf_count), 32'd0);
        chk("logic.exc", 32'(bus.ovf_exc), 32'd0);

        // bubble: controls gated, no count, no flag update
        clr_inputs();
        bus.ex_valid    = 1'b0;
        bus.ex_opcod    = 4'b0001;
        bus.ex_v        = 1'b1;
        bus.ex_regwrite = 1'b1;
        bus.ex_memread  = 1'b1;
        bus.ex_memwrite = 1'b1;
        bus.ex_br_cond  = 3'b111;
        bus.ex_alu_out  = 16'h0AAA;
        step();
        chk("bub.valid", 32'(bus.mem_valid), 32'd0);
        chk("bub.ctl", 32'({bus.mem_regwrite, bus.mem_memread,
                            bus.mem_memwrite}), 32'd0);
        chk("bub.br", 32'(bus.br_taken), 32'd0);
        chk("bub.ovfc", 32'(bus.ovf_count), 32'd0);
        chk("bub.flags", 32'(bus.flags), 32'b01100);
        chk("bub.alu", 32'(bus.mem_alu_out), 32'h0AAA);

        // signed overflow
        clr_inputs();
        bus.ex_opcod    = 4'b0001;
        bus.ex_v        = 1'b1;
        bus.ex_regwrite = 1'b1;
        bus.ex_memwrite = 1'b1;
        bus.ex_br_cond  = 3'b111;
        step();
        chk("ovf.cnt", 32'(bus.ovf_count), 32'd1);
        chk("ovf.flags", 32'(bus.flags), 32'b10000);
        chk("ovf.rw", 32'(bus.mem_regwrite), 32'(!TRAP));
        chk("ovf.mw", 32'(bus.mem_memwrite), 32'(!TRAP));
        chk("ovf.br", 32'(bus.br_taken), 32'(!TRAP));
        chk("ovf.exc", 32'(bus.ovf_exc), 32'(TRAP));

        // following normal load: pulse ends
        clr_inputs();
        bus.ex_regwrite = 1'b1;
        step();
        chk("post.exc", 32'(bus.ovf_exc), 32'd0);
        chk("post.cnt", 32'(bus.ovf_count), 32'd1);
        chk("post.rw", 32'(bus.mem_regwrite), 32'd1);
        chk("post.flags", 32'(bus.flags), 32'd0);

        // branch le with lt
        clr_inputs();
        bus.ex_opcod     = 4'b0010;
        bus.ex_br_cond   = 3'b101;
        bus.ex_lt        = 1'b1;
        bus.ex_br_target = 16'hBEEF;
        step();
        chk("le.br", 32'(bus.br_taken), 32'd1);
        chk("le.brt", 32'(bus.br_target), 32'hBEEF);

        // gt with gt=0, eq=1
        bus.ex_br_cond   = 3'b100;
        bus.ex_lt        = 1'b0;
        bus.ex_eq        = 1'b1;
        bus.ex_br_target = 16'h1357;
        step();
        chk("gt.br", 32'(bus.br_taken), 32'd0);
        chk("gt.brt", 32'(bus.br_target), 32'h1357);

        // ne with eq=0
        bus.ex_br_cond = 3'b010;
        bus.ex_eq      = 1'b0;
        step();
        chk("ne.br", 32'(bus.br_taken), 32'd1);

        // eq branch taken, then stall+flush
        clr_inputs();
        bus.ex_br_cond  = 3'b001;
        bus.ex_eq       = 1'b1;
        bus.ex_alu_out  = 16'h1111;
        bus.ex_regwrite = 1'b1;
        step();
        chk("eq.br", 32'(bus.br_taken), 32'd1);
        chk("eq.flags", 32'(bus.flags), 32'b00010);

        bus.stall      = 1'b1;
        bus.flush      = 1'b1;
        bus.ex_alu_out = 16'h2222;
        bus.ex_opcod   = 4'b0001;
        bus.ex_v       = 1'b1;
        step();
        chk("fl.br", 32'(bus.br_taken), 32'd0);
        chk("fl.valid", 32'(bus.mem_valid), 32'd0);
        chk("fl.rw", 32'(bus.mem_regwrite), 32'd0);
        chk("fl.alu", 32'(bus.mem_alu_out), 32'h1111);
        chk("fl.flags", 32'(bus.flags), 32'b00010);
        chk("fl.cnt", 32'(bus.ovf_count), 32'd1);

        // stall only for three cycles: frozen
        bus.flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step();
            chk("st.valid", 32'(bus.mem_valid), 32'd0);
            chk("st.alu", 32'(bus.mem_alu_out), 32'h1111);
            chk("st.br", 32'(bus.br_taken), 32'd0);
            chk("st.flags", 32'(bus.flags), 32'b00010);
            chk("st.cnt", 32'(bus.ovf_count), 32'd1);
            chk("st.exc", 32'(bus.ovf_exc), 32'd0);
        end

        // overflowing load then stall holds it
        bus.stall = 1'b0;
        clr_inputs();
        bus.ex_opcod    = 4'b0001;
        bus.ex_v        = 1'b1;
        bus.ex_cout     = 1'b1;
        bus.ex_regwrite = 1'b1;
        bus.ex_br_cond  = 3'b111;
        bus.ex_alu_out  = 16'h3333;
        step();
        chk("ovf2.cnt", 32'(bus.ovf_count), 32'd2);
        chk("ovf2.flags", 32'(bus.flags), 32'b11000);
        chk("ovf2.exc", 32'(bus.ovf_exc), 32'(TRAP));
        bus.stall = 1'b1;
        step();
        chk("sth.exc", 32'(bus.ovf_exc), 32'd0);
        chk("sth.cnt", 32'(bus.ovf_count), 32'd2);
        chk("sth.alu", 32'(bus.mem_alu_out), 32'h3333);
        chk("sth.valid", 32'(bus.mem_valid), 32'd1);
        chk("sth.br", 32'(bus.br_taken), 32'(!TRAP));

        // reset wins over stall and flush
        rst       = 1'b1;
        bus.flush = 1'b1;
        step();
        chk_all_zero("rstwin");

        // first edge after reset is a normal load
        rst       = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        clr_inputs();
        bus.ex_alu_out  = 16'h4444;
        bus.ex_regwrite = 1'b1;
        step();
        chk("rel.valid", 32'(bus.mem_valid), 32'd1);
        chk("rel.alu", 32'(bus.mem_alu_out), 32'h4444);
        chk("rel.rw", 32'(bus.mem_regwrite), 32'd1);

        // saturation after 300 overflows
        clr_inputs();
        bus.ex_opcod = 4'b0001;
        bus.ex_v     = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 254) chk("sat.255", 32'(bus.ovf_count), 32'd255);
        end
        chk("sat.cnt", 32'(bus.ovf_count), 32'd255);
        chk("sat.exc", 32'(bus.ovf_exc), 32'(TRAP));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
